register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wdec.sv | 23 ++
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the ARM-style register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned NUM_GPR        = 15;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

  localparam reg_addr_t PC_IDX = 4'd15;

endpackage

// File: rtl/regfile_wdec.sv
// One-hot write-enable decoder for the register file; the PC slot (top index) never enables.
module regfile_wdec
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [(2**ADDR_WIDTH)-1:0]   en
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  always_comb begin
    en = '0;
    if (we) begin
      en[addr] = 1'b1;
    end
    // R15 is owned by fetch; writes to it are dropped here.
    en[NumRegs-1] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// 15 stored GPRs plus a PC+8 pass-through at the top address; two async read ports, one write port.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] R15,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam int unsigned NumGpr  = NumRegs - 1;
  localparam logic [ADDR_WIDTH-1:0] PcAddr = ADDR_WIDTH'(NumGpr);

  logic [DATA_WIDTH-1:0] regs_q [NumGpr];
  logic [NumRegs-1:0]    wr_en;
  logic                  unused_pc_en;

  regfile_wdec #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wdec (
    .we  (WE3),
    .addr(A3),
    .en  (wr_en)
  );

  assign unused_pc_en = wr_en[NumGpr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumGpr; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumGpr; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= WD3;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass_en;
  assign bypass_en = WE3 && !reset && (A3 != PcAddr);
`endif

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    for (int unsigned i = 0; i < NumGpr; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        data = regs_q[i];
      end
    end
    if (addr == PcAddr) begin
      data = R15;
`ifdef REGFILE_BYPASS_EN
    end else if (bypass_en && (addr == A3)) begin
      data = WD3;
`endif
    end
    return data;
  endfunction

  always_comb begin
    RD1 = read_port(A1);
  end

  always_comb begin
    RD2 = read_port(A2);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed literal checks plus randomized traffic
// compared every cycle against an array model of the architectural registers.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE3 = 1'b0;
  logic [3:0]  A1 = '0;
  logic [3:0]  A2 = '0;
  logic [3:0]  A3 = '0;
  logic [31:0] WD3 = '0;
  logic [31:0] R15 = '0;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [31:0] model [15] = '{default: 32'h0};

  register_file dut (
    .clk  (clk),
    .reset(reset),
    .WE3  (WE3),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .WD3  (WD3),
    .R15  (R15),
    .RD1  (RD1),
    .RD2  (RD2)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural state: reset clears everything, writes to R15 vanish.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) model[i] = 32'h0;
    end else if (WE3 && A3 != 4'd15) begin
      model[A3] = WD3;
    end
  end

  function automatic logic [31:0] expect_rd(input logic [3:0] a);
    if (a == 4'd15) return R15;
`ifdef REGFILE_BYPASS_EN
    if (WE3 && !reset && A3 != 4'd15 && a == A3) return WD3;
`endif
    return model[a];
  endfunction

  // Mid-cycle comparison: inputs change just after posedge, model settles at the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("cyc_rd1 t=%0t a=%0d", $time, A1), RD1, expect_rd(A1));
      check($sformatf("cyc_rd2 t=%0t a=%0d", $time, A2), RD2, expect_rd(A2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    step();
    WE3 = 1'b0;
  endtask

  initial begin
    logic [31:0] old5;
    // Reset state and R15 pass-through during reset.
    step();
    chk_en = 1'b1;
    check("reset_rd1", RD1, 32'h0);
    check("reset_rd2", RD2, 32'h0);
    A1 = 4'd15; R15 = 32'h1; #1;
    check("reset_r15", RD1, 32'h1);
    // A write attempted under reset must be blocked.
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'hFFFF_FFFF;
    step();
    WE3 = 1'b0; reset = 1'b0; #1;
    A1 = 4'd2; #1;
    check("write_in_reset", RD1, 32'h0);

    // Basic write and hold.
    wr(4'd0, 32'h1);
    A1 = 4'd0; #1;
    check("basic_write", RD1, 32'h1);
    WD3 = 32'h99;
    step();
    check("hold_no_we", RD1, 32'h1);

    // Overwrite sequence.
    wr(4'd0, 32'h3);
    A1 = 4'd0; A2 = 4'd0; #1;
    check("ovw_rd1_3", RD1, 32'h3);
    check("ovw_rd2_3", RD2, 32'h3);
    wr(4'd0, 32'h7);
    check("ovw_rd1_7", RD1, 32'h7);
    check("ovw_rd2_7", RD2, 32'h7);

    // R15: writes ignored, reads return the input.
    R15 = 32'h108; A1 = 4'd15;
    wr(4'd15, 32'hDEAD);
    check("r15_read", RD1, 32'h108);
    A2 = 4'd0; #1;
    check("r15_no_side", RD2, 32'h7);

    // Distinct registers read simultaneously.
    wr(4'd3, 32'hAAAA5555);
    wr(4'd14, 32'h12345678);
    A1 = 4'd3; A2 = 4'd14; #1;
    check("dual_r3", RD1, 32'hAAAA5555);
    check("dual_r14", RD2, 32'h12345678);

    // Async reset clears before the next edge.
    #1 reset = 1'b1; #1;
    check("async_rst_r3", RD1, 32'h0);
    check("async_rst_r14", RD2, 32'h0);
    step();
    reset = 1'b0; #1;

    // Read-during-write on the same register.
    wr(4'd5, 32'h11);
    WE3 = 1'b1; A3 = 4'd5; A1 = 4'd5; WD3 = 32'h55; #1;
`ifdef REGFILE_BYPASS_EN
    old5 = 32'h55;
`else
    old5 = 32'h11;
`endif
    check("rdw_before_edge", RD1, old5);
    step();
    WE3 = 1'b0; #1;
    check("rdw_after_edge", RD1, 32'h55);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      WE3   = ($urandom_range(0, 3) != 0);
      A3    = 4'($urandom_range(0, 15));
      WD3   = $urandom;
      R15   = $urandom;
      A1    = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, 15));
      A2    = ($urandom_range(0, 3) == 0) ? A3 : 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0; WE3 = 1'b0;
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
